// File: rtl/alu_req_arbiter.sv
// Two-port round-robin request arbiter and sequencer for the shared 8-bit registered ALU.
// Accepts one command at a time, waits out the ALU latency and returns a tagged response.
module alu_req_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_sel,
    input  logic [7:0] alu_out,
    input  logic       alu_carry,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_result,
    output logic       rsp_carry,
    output logic       rsp_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    localparam logic [3:0] OP_DIV = 4'd3;

    state_t     state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic [3:0] op_q, op_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic       id_q, id_d;
    logic       rsp_id_q, rsp_id_d;
    logic [7:0] rsp_result_q, rsp_result_d;
    logic       rsp_carry_q, rsp_carry_d;
    logic       rsp_err_q, rsp_err_d;
    logic       grant1;

    // Port 1 wins when it is the only requester, or on contention when port 0 was served last.
    assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_err_d    = rsp_err_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Ready is gated by rst so a reset cycle never completes a handshake.
                if (!rst && (req0_valid || req1_valid)) begin
                    req0_ready   = !grant1;
                    req1_ready   = grant1;
                    last_grant_d = grant1;
                    id_d         = grant1;
                    op_d         = grant1 ? req1_op : req0_op;
                    a_d          = grant1 ? req1_a  : req0_a;
                    b_d          = grant1 ? req1_b  : req0_b;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                rsp_id_d = id_q;
                if (op_q == OP_DIV && b_q == 8'h00) begin
                    rsp_result_d = 8'h00;
                    rsp_carry_d  = 1'b0;
                    rsp_err_d    = 1'b1;
                end else begin
                    rsp_result_d = alu_out;
                    rsp_carry_d  = alu_carry;
                    rsp_err_d    = 1'b0;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            op_q         <= 4'h0;
            a_q          <= 8'h00;
            b_q          <= 8'h00;
            id_q         <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 8'h00;
            rsp_carry_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_sel    = op_q;
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: a transaction-level model checked every cycle,
// a registered ALU stand-in, and directed scenarios with hand-computed expectations.
module tb_alu_req_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err, busy;
    logic [7:0] rsp_result;

    always #5 clk = ~clk;

    alu_req_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_err(rsp_err), .busy(busy)
    );

    // ALU stand-in: registered result, combinational carry of a+b. Divide by zero yields FF.
    function automatic logic [7:0] alu_f(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
        case (sel)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a * b;
            4'd3:    return (b == 8'h00) ? 8'hFF : a / b;
            4'd4:    return (b == 8'h00) ? 8'hFF : a % b;
            4'd5:    return a << b[2:0];
            4'd6:    return a >> b[2:0];
            4'd7:    return ~a;
            4'd8:    return a & b;
            4'd9:    return a | b;
            4'd10:   return a ^ b;
            4'd11:   return ~(a & b);
            4'd12:   return {7'd0, a < b};
            4'd13:   return (a > b) ? a : b;
            4'd14:   return {7'd0, a > b};
            default: return {7'd0, a == b};
        endcase
    endfunction

    logic [8:0] alu_sum;
    assign alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_carry = alu_sum[8];
    always @(posedge clk) alu_out <= alu_f(alu_sel, alu_a, alu_b);

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct packed {
        logic       id;
        logic [7:0] res;
        logic       carry;
        logic       err;
    } rsp_t;

    function automatic rsp_t expect_rsp(input logic id, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        rsp_t r;
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        r.id = id;
        if (op == 4'd3 && b == 8'h00) begin
            r.res = 8'h00; r.carry = 1'b0; r.err = 1'b1;
        end else begin
            r.res = alu_f(op, a, b); r.carry = s[8]; r.err = 1'b0;
        end
        return r;
    endfunction

    // Which port wins: the lone requester, or on contention the one not served last.
    function automatic logic pick1(input logic v0, input logic v1, input logic lg);
        return (v0 && v1) ? !lg : v1;
    endfunction

    bit         armed = 0;
    bit         m_busy;
    int         m_age;      // cycles elapsed since the accept edge
    logic       m_lg;
    logic [3:0] m_op;
    logic [7:0] m_a, m_b;
    rsp_t       m_pend, m_shown;

    always @(posedge clk) begin
        if (rst) begin
            armed   <= 1;
            m_busy  <= 0;
            m_age   <= 0;
            m_lg    <= 1'b1;
            m_op    <= 4'h0;
            m_a     <= 8'h00;
            m_b     <= 8'h00;
            m_pend  <= '0;
            m_shown <= '0;
        end else if (!m_busy) begin
            if (req0_valid || req1_valid) begin
                m_busy <= 1;
                m_age  <= 1;
                m_lg   <= pick1(req0_valid, req1_valid, m_lg);
                m_op   <= pick1(req0_valid, req1_valid, m_lg) ? req1_op : req0_op;
                m_a    <= pick1(req0_valid, req1_valid, m_lg) ? req1_a : req0_a;
                m_b    <= pick1(req0_valid, req1_valid, m_lg) ? req1_b : req0_b;
                m_pend <= pick1(req0_valid, req1_valid, m_lg)
                          ? expect_rsp(1'b1, req1_op, req1_a, req1_b)
                          : expect_rsp(1'b0, req0_op, req0_a, req0_b);
            end
        end else if (m_age < 3) begin
            m_age <= m_age + 1;
            if (m_age == 2) m_shown <= m_pend;
        end else if (rsp_ready) begin
            m_busy <= 0;
        end
    end

    // Compare process: every negedge once reset has been seen.
    always @(negedge clk) begin
        if (armed) begin
            check("req0_ready", req0_ready,
                  !rst && !m_busy && req0_valid && !pick1(req0_valid, req1_valid, m_lg));
            check("req1_ready", req1_ready,
                  !rst && !m_busy && pick1(req0_valid, req1_valid, m_lg));
            check("busy", busy, m_busy);
            check("rsp_valid", rsp_valid, m_busy && m_age >= 3);
            check("alu_a", alu_a, m_a);
            check("alu_b", alu_b, m_b);
            check("alu_sel", alu_sel, m_op);
            check("rsp_id", rsp_id, m_shown.id);
            check("rsp_result", rsp_result, m_shown.res);
            check("rsp_carry", rsp_carry, m_shown.carry);
            check("rsp_err", rsp_err, m_shown.err);
        end
    end

    // ---------------- monitors ----------------
    typedef struct packed {
        logic       id;
        logic [7:0] res;
    } log_t;

    log_t rsp_log[$];
    int   cyc = 0;
    int   r0_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid && rsp_ready) rsp_log.push_back('{id: rsp_id, res: rsp_result});
            if (req0_ready) r0_pulses <= r0_pulses + 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    int   acc_cyc[8];
    logic acc_id[8];

    task automatic align();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input bit port, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bit ok;
        ok = 0;
        if (port) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
        else      begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (port ? req1_ready : req0_ready) begin ok = 1; break; end
        end
        align();
        if (port) req1_valid = 0; else req0_valid = 0;
        if (!ok) check("send_accept_timeout", 0, 1);
    endtask

    task automatic wait_rsp(output int n);
        bit ok;
        ok = 0;
        n  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (rsp_valid) begin ok = 1; break; end
        end
        if (!ok) check("rsp_valid_timeout", 0, 1);
    endtask

    task automatic wait_log(input int target);
        for (int i = 0; i < 60; i++) begin
            if (rsp_log.size() >= target) break;
            @(posedge clk);
        end
        check("rsp_count", rsp_log.size(), target);
        #2;
    endtask

    // Both ports request continuously until n accepts have been seen.
    task automatic contend(input int n,
                           input logic [3:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                           input logic [3:0] op1, input logic [7:0] a1, input logic [7:0] b1);
        int k;
        k = 0;
        req0_valid = 1; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = 1; req1_op = op1; req1_a = a1; req1_b = b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                acc_id[k]  = req1_ready;
                acc_cyc[k] = cyc;
                k++;
                if (k == n) break;
            end
        end
        align();
        req0_valid = 0;
        req1_valid = 0;
        check("contend_accepts", k, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int n;
        int base;
        rst = 1; rsp_ready = 1;
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_alu_a", alu_a, 0);
        check("reset_rsp_result", rsp_result, 0);
        align();
        rst = 0;
        align();

        // Contention from reset: port 0 first, then alternating, one accept every 4 cycles.
        base = rsp_log.size();
        contend(4, 4'd2, 8'd3, 8'd5, 4'd8, 8'hCC, 8'hAA);
        wait_log(base + 4);
        for (int k = 0; k < 4; k++) begin
            check("contend_id", rsp_log[base + k].id, k % 2);
            check("contend_result", rsp_log[base + k].res, (k % 2 == 0) ? 8'h0F : 8'h88);
            check("contend_accept_id", acc_id[k], k % 2);
            if (k > 0) check("contend_spacing", acc_cyc[k] - acc_cyc[k - 1], 4);
        end
        align();

        // Single add with carry out, response three cycles after accept.
        send(0, 4'd0, 8'hF0, 8'h20);
        wait_rsp(n);
        check("add_latency", n, 3);
        check("add_result", rsp_result, 8'h10);
        check("add_carry", rsp_carry, 1);
        check("add_id", rsp_id, 0);
        check("add_err", rsp_err, 0);
        align();

        // Divide by zero then a legal divide.
        send(0, 4'd3, 8'h40, 8'h00);
        wait_rsp(n);
        check("div0_latency", n, 3);
        check("div0_result", rsp_result, 8'h00);
        check("div0_err", rsp_err, 1);
        check("div0_carry", rsp_carry, 0);
        align();
        send(0, 4'd3, 8'h40, 8'h04);
        wait_rsp(n);
        check("div_result", rsp_result, 8'h10);
        check("div_err", rsp_err, 0);
        align();

        // Backpressure: response held, no readies, ALU inputs frozen, a waiting request blocked.
        rsp_ready = 0;
        send(1, 4'd14, 8'd9, 8'd4);
        wait_rsp(n);
        align();
        req0_valid = 1; req0_op = 4'd0; req0_a = 8'd1; req0_b = 8'd2;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_result", rsp_result, 8'h01);
            check("bp_id", rsp_id, 1);
            check("bp_busy", busy, 1);
            check("bp_req0_ready", req0_ready, 0);
            check("bp_alu_a", alu_a, 8'd9);
            check("bp_alu_b", alu_b, 8'd4);
            check("bp_alu_sel", alu_sel, 4'd14);
        end
        align();
        rsp_ready = 1;
        align();
        @(negedge clk);
        check("bp_release_idle", busy, 0);
        check("bp_release_accept", req0_ready, 1);
        align();
        req0_valid = 0;
        wait_rsp(n);
        check("bp_next_result", rsp_result, 8'h03);
        align();

        // Single requester on port 1, three back-to-back requests.
        base = rsp_log.size();
        n = r0_pulses;
        send(1, 4'd1, 8'd10, 8'd3);
        send(1, 4'd9, 8'h50, 8'h0A);
        send(1, 4'd15, 8'd7, 8'd7);
        wait_log(base + 3);
        check("single_r0_pulses", r0_pulses - n, 0);
        check("single_id0", rsp_log[base].id, 1);
        check("single_res0", rsp_log[base].res, 8'h07);
        check("single_id1", rsp_log[base + 1].id, 1);
        check("single_res1", rsp_log[base + 1].res, 8'h5A);
        check("single_id2", rsp_log[base + 2].id, 1);
        check("single_res2", rsp_log[base + 2].res, 8'h01);
        align();

        // Reset during CAPTURE drops the command; port 0 then wins contention.
        base = rsp_log.size();
        send(0, 4'd8, 8'hFF, 8'h0F);
        align();
        rst = 1;
        align();
        rst = 0;
        @(negedge clk);
        check("rstmid_busy", busy, 0);
        check("rstmid_rsp_valid", rsp_valid, 0);
        check("rstmid_alu_a", alu_a, 0);
        check("rstmid_alu_b", alu_b, 0);
        check("rstmid_alu_sel", alu_sel, 0);
        check("rstmid_rsp_result", rsp_result, 0);
        check("rstmid_rsp_id", rsp_id, 0);
        repeat (5) @(negedge clk);
        check("rstmid_no_rsp", rsp_log.size(), base);
        align();
        contend(2, 4'd0, 8'd1, 8'd1, 4'd0, 8'd2, 8'd2);
        check("rstmid_first_grant", acc_id[0], 0);
        check("rstmid_second_grant", acc_id[1], 1);
        wait_log(base + 2);
        check("rstmid_res0", rsp_log[base].res, 8'd2);
        check("rstmid_res1", rsp_log[base + 1].res, 8'd4);
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
